mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage pipeline. Sits between the EXE/MEM pipeline register and the MEM/WB register. Consumes the EXE/MEM outputs: ALU result used as byte address, memory-control bits, destination register and PC. Holds a word-addressed data memory, performs loads and stores, emulates SRAM wait states with a stall FSM, and forwards write-back control unchanged.

## Interface

Parameters:
- DEPTH_LOG2, 6, log2 of data-memory depth in 32-bit words (64 words).
- BASE_ADDR, 1024, byte address mapped to word 0.
- WAIT_CYCLES, 3, SRAM wait cycles per access; legal range is ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_in  in  32  PC from EXE/MEM.
- alu_result_in  in  32  byte address for loads/stores; pass-through value otherwise.
- store_val  in  32  store data.
- mem_read  in  1  load request.
- mem_write  in  1  store request.
- wb_en_in  in  1  write-back enable.
- dest_in  in  5  destination register.
- pc_out  out  32  pc_in pass-through.
- alu_result_out  out  32  alu_result_in pass-through.
- mem_data_out  out  32  load data.
- wb_en_out  out  1  wb_en_in pass-through.
- mem_read_out  out  1  mem_read pass-through; drives the WB mux select.
- dest_out  out  5  dest_in pass-through.
- freeze  out  1  stall request to all upstream pipeline registers and the PC.

## Operation

- Word index = ((alu_result_in − BASE_ADDR) >> 2) mod 2^DEPTH_LOG2.
  - Subtraction is 32-bit with wrap-around.
  - Bits [1:0] of the address are ignored.
  - Out-of-range addresses alias into the array; there is no fault.
- Pass-through outputs are purely combinational from their inputs. They read 0 during reset because the EXE/MEM register resets to 0.
- Memory array: 2^DEPTH_LOG2 × 32. All words clear to 0 on reset.
- mem_read and mem_write both set is defined behaviour:
  - The write is performed.
  - mem_data_out returns the pre-write contents of the word.
- Upstream holds all inputs stable while freeze = 1.
- No-op (mem_read = mem_write = 0): no state change; freeze = 0.
- mem_data_out is 0 after reset.

## Timing

With SRAM_WAIT_EN, a 2-bit FSM plus a counter of width clog2(WAIT_CYCLES+1):
- **IDLE**
  - freeze = mem_read | mem_write, combinational, same cycle as the request arrives.
  - On a request, go to WAIT with cnt = 0.
- **WAIT**
  - freeze = 1.
  - cnt increments each cycle.
  - When cnt == WAIT_CYCLES−1:
    - commit the write to the array, or latch the read word into rdata_reg;
    - go to DONE.
- **DONE**
  - freeze = 0; mem_data_out = rdata_reg.
  - The pipeline advances on this edge.
  - Always returns to IDLE, so the same held instruction never retriggers.

Timing consequences:
- A memory op holds freeze high for WAIT_CYCLES+1 cycles, then one DONE cycle. Total stage occupancy is WAIT_CYCLES+2 cycles.
- A back-to-back memory op arrives in IDLE on the cycle after DONE and restarts the sequence.
- mem_data_out holds rdata_reg until the next read commit.
- Reset mid-operation:
  - the FSM goes to IDLE, cnt = 0, rdata_reg = 0, freeze drops immediately;
  - an uncommitted store is discarded.

## Configuration

- SRAM_WAIT_EN defined: FSM, counter and rdata_reg are present, as described under Timing.
- SRAM_WAIT_EN undefined:
  - freeze is tied to 0; there is no FSM or counter.
  - The write commits on the rising edge when mem_write = 1.
  - mem_data_out is a combinational array read at the current index.
  - Reset behaviour of the array is unchanged.

## Test plan

Defaults apply unless stated: DEPTH_LOG2 = 6, BASE_ADDR = 1024, WAIT_CYCLES = 3.

1. **Reset.** Assert rst mid-run → all outputs 0, freeze 0; a load of 1024 after release returns 0.
2. **Store/load (SRAM_WAIT_EN).** Store 0xDEADBEEF to 1028 → freeze high 4 cycles, low in DONE. Then load 1028 → freeze high 4 cycles; mem_data_out = 0xDEADBEEF in the DONE cycle.
3. **Non-memory op.** wb_en_in = 1, alu_result_in = 0x55, dest_in = 7 → freeze stays 0; wb_en_out = 1, alu_result_out = 0x55, dest_out = 7 in the same cycle.
4. **Alias/misalignment.**
   - Store 0x12345678 to 1280 → a load of 1024 returns 0x12345678.
   - Store 0x0BADF00D to 1027 → a load of 1024 returns 0x0BADF00D.
5. **Reset during WAIT.** Store 0xAAAA5555 to 1032; assert rst in WAIT (cnt = 1) → freeze falls that cycle; a later load of 1032 returns 0.
6. **Macro off.** Store 0xCAFEF00D to 1036, then load 1036 on the next cycle → freeze never asserts; mem_data_out = 0xCAFEF00D in the load cycle.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bus bundle between the EXE/MEM register, the memory stage and the MEM/WB register.
// Upstream drives through the master modport; mem_stage consumes it through the slave modport.
interface mem_stage_if;
  logic [31:0] pc_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_val;
  logic        mem_read;
  logic        mem_write;
  logic        wb_en_in;
  logic [4:0]  dest_in;
  logic [31:0] pc_out;
  logic [31:0] alu_result_out;
  logic [31:0] mem_data_out;
  logic        wb_en_out;
  logic        mem_read_out;
  logic [4:0]  dest_out;
  logic        freeze;

  modport master (
    output pc_in, alu_result_in, store_val, mem_read, mem_write, wb_en_in, dest_in,
    input  pc_out, alu_result_out, mem_data_out, wb_en_out, mem_read_out, dest_out, freeze
  );

  modport slave (
    input  pc_in, alu_result_in, store_val, mem_read, mem_write, wb_en_in, dest_in,
    output pc_out, alu_result_out, mem_data_out, wb_en_out, mem_read_out, dest_out, freeze
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word-addressed data memory, loads/stores, WB pass-through.
// Optional macro SRAM_WAIT_EN adds an SRAM wait-state FSM that freezes the upstream pipeline.
module mem_stage #(
  parameter int DEPTH_LOG2  = 6,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           rd_word;
  logic                  req;
  logic                  wr_en;
  logic                  unused_addr_bits;

  // Out-of-range addresses simply wrap into the array; byte offset is dropped.
  assign off              = bus.alu_result_in - 32'(BASE_ADDR);
  assign idx              = off[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{off[31:DEPTH_LOG2+2], off[1:0]};
  assign rd_word          = mem_q[idx];
  assign req              = bus.mem_read | bus.mem_write;

  assign bus.pc_out         = bus.pc_in;
  assign bus.alu_result_out = bus.alu_result_in;
  assign bus.wb_en_out      = bus.wb_en_in;
  assign bus.mem_read_out   = bus.mem_read;
  assign bus.dest_out       = bus.dest_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= bus.store_val;
    end
  end

`ifdef SRAM_WAIT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          last;

  assign last = (cnt_q == CW'(WAIT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    wr_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          // Read latches the pre-write word when both read and write are set.
          state_d = S_DONE;
          cnt_d   = '0;
          wr_en   = bus.mem_write;
          if (bus.mem_read) rdata_d = rd_word;
        end
      end
      // DONE always drops back so the held instruction cannot retrigger.
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.freeze       = !rst && ((state_q == S_IDLE) ? req : (state_q == S_WAIT));
  assign bus.mem_data_out = rdata_q;
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
  logic          unused_req;

  assign unused_req       = req;
  assign wr_en            = bus.mem_write;
  assign bus.freeze       = 1'b0;
  assign bus.mem_data_out = rd_word;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a word-array reference model.
// Adapts its timing expectations to whether SRAM_WAIT_EN is defined.
module tb_mem_stage;
`ifdef SRAM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] model [64];
  logic [31:0] last_rd;

  mem_stage_if bus ();

  mem_stage #(
    .DEPTH_LOG2 (6),
    .BASE_ADDR  (1024),
    .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    logic [31:0] d;
    d = a - 32'd1024;
    return int'((d / 4) % 64);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model[i] = '0;
    last_rd = '0;
  endtask

  task automatic drive_idle();
    bus.pc_in = '0; bus.alu_result_in = '0; bus.store_val = '0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.wb_en_in = 1'b0; bus.dest_in = '0;
  endtask

  // One instruction through the stage; returns what mem_data_out showed when the stage released it.
  task automatic op(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                    input bit wb, input logic [4:0] dest, output logic [31:0] seen);
    int          i;
    int          hi;
    logic [31:0] pre;
    logic [31:0] pc;
    i   = widx(addr);
    pre = model[i];
    pc  = $urandom;
    bus.pc_in = pc; bus.alu_result_in = addr; bus.store_val = wdata;
    bus.mem_read = rd; bus.mem_write = wr; bus.wb_en_in = wb; bus.dest_in = dest;
    @(negedge clk);
    chk("pc_out", bus.pc_out, pc);
    chk("alu_out", bus.alu_result_out, addr);
    chk("wb_en_out", 32'(bus.wb_en_out), 32'(wb));
    chk("dest_out", 32'(bus.dest_out), 32'(dest));
    chk("mem_read_out", 32'(bus.mem_read_out), 32'(rd));
    if (WAIT_EN && (rd || wr)) begin
      hi = 0;
      while (bus.freeze === 1'b1 && hi < 40) begin
        hi++;
        @(negedge clk);
      end
      chk("freeze_cycles", 32'(hi), 32'(W + 1));
      if (rd) last_rd = pre;
      chk("done_data", bus.mem_data_out, last_rd);
    end else begin
      chk("freeze_low", 32'(bus.freeze), 32'd0);
      if (WAIT_EN) chk("hold_data", bus.mem_data_out, last_rd);
      else         chk("comb_data", bus.mem_data_out, pre);
    end
    seen = bus.mem_data_out;
    if (wr) model[i] = wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] got;
    int          k;
    logic [31:0] a;
    drive_idle();
    clear_model();

    // Power-on reset
    @(negedge clk);
    chk("rst_freeze", 32'(bus.freeze), 32'd0);
    chk("rst_data", bus.mem_data_out, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Store/load and non-memory op
    op(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, 5'd0, got);
    op(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, 5'd3, got);
    chk("t2_load", got, 32'hDEADBEEF);
    op(1'b0, 1'b0, 32'h55, 32'h0, 1'b1, 5'd7, got);

    // Aliasing and misalignment
    op(1'b0, 1'b1, 32'd1280, 32'h12345678, 1'b0, 5'd0, got);
    op(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, 5'd1, got);
    chk("alias_load", got, 32'h12345678);
    op(1'b0, 1'b1, 32'd1027, 32'h0BADF00D, 1'b0, 5'd0, got);
    op(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, 5'd1, got);
    chk("misalign_load", got, 32'h0BADF00D);

    // Store then load back-to-back, plus read+write in the same op
    op(1'b0, 1'b1, 32'd1036, 32'hCAFEF00D, 1'b0, 5'd0, got);
    op(1'b1, 1'b0, 32'd1036, 32'h0, 1'b1, 5'd2, got);
    chk("b2b_load", got, 32'hCAFEF00D);
    op(1'b1, 1'b1, 32'd1036, 32'h11112222, 1'b1, 5'd2, got);
    chk("rw_pre", got, 32'hCAFEF00D);
    op(1'b1, 1'b0, 32'd1036, 32'h0, 1'b1, 5'd2, got);
    chk("rw_post", got, 32'h11112222);

    // Mid-run reset with the upstream register cleared
    rst = 1'b1;
    drive_idle();
    #1;
    chk("mid_rst_freeze", 32'(bus.freeze), 32'd0);
    chk("mid_rst_data", bus.mem_data_out, 32'd0);
    chk("mid_rst_pc", bus.pc_out, 32'd0);
    chk("mid_rst_alu", bus.alu_result_out, 32'd0);
    chk("mid_rst_ctl", 32'({bus.wb_en_out, bus.mem_read_out, bus.dest_out}), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    clear_model();
    op(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 5'd0, got);
    chk("post_rst_load", got, 32'd0);

    // Reset while a store is waiting on the SRAM
    if (WAIT_EN) begin
      bus.alu_result_in = 32'd1032; bus.store_val = 32'hAAAA5555;
      bus.mem_write = 1'b1; bus.mem_read = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("wait_freeze", 32'(bus.freeze), 32'd1);
      rst = 1'b1;
      #1;
      chk("wait_rst_freeze", 32'(bus.freeze), 32'd0);
      drive_idle();
      @(posedge clk); #1; rst = 1'b0;
      clear_model();
      op(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, 5'd0, got);
      chk("wait_rst_load", got, 32'd0);
    end

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      k = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'd1024 + 32'($urandom_range(0, 511));
      op(k[0], k[1], a, $urandom, 1'($urandom), 5'($urandom), got);
    end

    drive_idle();
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
